// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types for the instruction fetch controller: FSM states, queue entry
// layout and the address-legality rule used when deciding whether to push.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

  localparam logic [15:0] PC_STEP = 16'd4;

  // Word-aligned and the whole 4-byte word inside memory; sum kept 17 bits so
  // addresses near 16'hFFFF cannot wrap into the legal range.
  function automatic logic addr_legal(input logic [15:0] pc, input int unsigned mem_size);
    logic [16:0] last;
    last = {1'b0, pc} + 17'd3;
    return (pc[1:0] == 2'b00) && ({15'd0, last} < 32'(mem_size));
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side buses: combinational ROM port and the instruction output handshake.
interface instr_fetch_ctrl_if;

  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready;

  modport master (
    output imem_addr,
    input  imem_instr,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/instr_fetch_ctrl_queue.sv
// Circular prefetch FIFO of {pc, instr} entries. Flush wins over push/pop;
// push into a full queue is accepted only when the head leaves the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; occupancy is tracked by the control registers above.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks a combinational ROM four bytes at a time
// into a small prefetch queue, with halt, redirect and bad-address fault handling.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024,
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 redirect,
  input  logic [15:0]          redirect_pc,
  instr_fetch_ctrl_if.master   bus,
  output logic                 fault,
  output logic [15:0]          fault_pc,
  output logic                 busy
);

  fetch_state_e state_q, state_d;
  logic [15:0]  fetch_pc_q, fetch_pc_d;
  logic [15:0]  fault_pc_q, fault_pc_d;
  fetch_entry_t last_q, last_d;

  logic         q_flush, q_push, q_pop, q_full, q_empty;
  logic         pc_legal, head_pop;
  fetch_entry_t head, new_entry;

  assign pc_legal  = addr_legal(fetch_pc_q, MEM_SIZE);
  assign head_pop  = !q_empty && bus.out_ready;
  assign new_entry = '{pc: fetch_pc_q, instr: bus.imem_instr};

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (reset),
    .flush (q_flush),
    .push  (q_push),
    .pop   (q_pop),
    .wdata (new_entry),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty)
  );

  // Priority inside FETCH/FAULT: halt, then redirect, then normal push/pop.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fault_pc_d = fault_pc_q;
    q_flush    = 1'b0;
    q_push     = 1'b0;
    q_pop      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_d    = ST_FETCH;
          fetch_pc_d = RESET_PC;
          q_flush    = 1'b1;
        end
      end
      ST_FETCH, ST_FAULT: begin
        if (halt) begin
          state_d = ST_HALTED;
          q_flush = 1'b1;
        end else if (redirect) begin
          state_d    = ST_FETCH;
          fetch_pc_d = redirect_pc;
          q_flush    = 1'b1;
        end else if (state_q == ST_FETCH) begin
          q_pop = head_pop;
          if (pc_legal) begin
            if (!q_full || head_pop) begin
              q_push     = 1'b1;
              fetch_pc_d = fetch_pc_q + PC_STEP;
            end
          end else if (q_empty) begin
            // Only fault once everything fetched before the bad address is gone.
            state_d    = ST_FAULT;
            fault_pc_d = fetch_pc_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Remembers the most recent head so the outputs hold steady while empty.
  assign last_d = q_empty ? last_q : head;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      fault_pc_q <= '0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fault_pc_q <= fault_pc_d;
      last_q     <= last_d;
    end
  end

  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = !q_empty;
  assign bus.out_pc    = q_empty ? last_q.pc    : head.pc;
  assign bus.out_instr = q_empty ? last_q.instr : head.instr;
  assign fault         = (state_q == ST_FAULT);
  assign fault_pc      = fault_pc_q;
  assign busy          = (state_q == ST_FETCH);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus a random
// run, all compared against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam int unsigned MEM_SIZE = 1024;
  localparam int          DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  localparam int M_IDLE = 0, M_FETCH = 1, M_HALTED = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        fault;
  logic [15:0] fault_pc;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl #(
    .MEM_SIZE (MEM_SIZE),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus),
    .fault       (fault),
    .fault_pc    (fault_pc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  assign bus.imem_instr = rom(bus.imem_addr);

  // Reference model: state as an integer, the prefetch queue as a SV queue.
  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_last;
  ent_t        m_new;
  int          m_state = M_IDLE;
  logic [15:0] m_pc = RESET_PC;
  logic [15:0] m_fpc = 16'h0;
  bit          m_had, m_pop, m_legal, m_valid;
  int unsigned m_addr;
  logic [66:0] exp_vec = '0;

  wire [66:0] obs_vec = {bus.out_valid, bus.out_pc, bus.out_instr, fault,
                         (fault ? fault_pc : 16'h0), busy, bus.imem_addr};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = M_IDLE;
      m_pc    = RESET_PC;
      m_fpc   = 16'h0;
      mq.delete();
      m_last  = '{16'h0, 16'h0};
    end else begin
      m_had = (mq.size() > 0);
      m_pop = m_had && bus.out_ready;
      if (m_had) m_last = mq[0];
      if (m_state == M_IDLE || m_state == M_HALTED) begin
        if (start) begin
          m_state = M_FETCH;
          m_pc    = RESET_PC;
          mq.delete();
        end
      end else if (halt) begin
        m_state = M_HALTED;
        mq.delete();
      end else if (redirect) begin
        m_state = M_FETCH;
        m_pc    = redirect_pc;
        mq.delete();
      end else if (m_state == M_FETCH) begin
        m_addr  = int'(m_pc);
        m_legal = (m_addr % 4 == 0) && (m_addr + 3 < MEM_SIZE);
        if (m_pop) void'(mq.pop_front());
        if (m_legal && mq.size() < DEPTH) begin
          m_new.pc    = m_pc;
          m_new.instr = rom(m_pc);
          mq.push_back(m_new);
          m_pc = m_pc + 16'd4;
        end else if (!m_legal && !m_had) begin
          m_state = M_FAULT;
          m_fpc   = m_pc;
        end
      end
    end
    m_valid = (mq.size() > 0);
    if (m_valid)
      exp_vec = {1'b1, mq[0].pc, mq[0].instr, m_state == M_FAULT,
                 (m_state == M_FAULT) ? m_fpc : 16'h0, m_state == M_FETCH, m_pc};
    else
      exp_vec = {1'b0, m_last.pc, m_last.instr, m_state == M_FAULT,
                 (m_state == M_FAULT) ? m_fpc : 16'h0, m_state == M_FETCH, m_pc};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_instr, fault, fault_pc, busy, bus.imem_addr}
        !== {1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, RESET_PC}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b pc=%h in=%h f=%b fpc=%h b=%b a=%h expected all zero, addr=%h",
               bus.out_valid, bus.out_pc, bus.out_instr, fault, fault_pc, busy, bus.imem_addr, RESET_PC);
    end
    n_checks++;
    if (obs_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL reset_model: got %h expected %h", obs_vec, exp_vec);
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({bus.out_valid, busy, bus.imem_addr} !== {1'b0, 1'b1, 16'h0}) begin
      n_fail++;
      $display("FAIL stream_load: got v=%b busy=%b addr=%h expected v=0 busy=1 addr=0000",
               bus.out_valid, busy, bus.imem_addr);
    end
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 16'h0, rom(16'h0)}) begin
      n_fail++;
      $display("FAIL stream_first: got v=%b pc=%h instr=%h expected v=1 pc=0000 instr=%h",
               bus.out_valid, bus.out_pc, bus.out_instr, rom(16'h0));
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_pc} !== {1'b1, 16'(4 * i)} || obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL stream_seq[%0d]: got v=%b pc=%h (%h) expected v=1 pc=%h (%h)",
                 i, bus.out_valid, bus.out_pc, obs_vec, 16'(4 * i), exp_vec);
      end
    end
    halt = 1'b1;
    tick();
    halt = 1'b0;
    n_checks++;
    if ({bus.out_valid, busy, fault} !== 3'b000 || obs_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL stream_halt: got v=%b busy=%b fault=%b expected 0 0 0", bus.out_valid, busy, fault);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got %h expected %h", i, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if ({bus.out_valid, bus.out_pc, bus.imem_addr} !== {1'b1, 16'h0, 16'h8}) begin
      n_fail++;
      $display("FAIL bp_full: got v=%b pc=%h addr=%h expected v=1 pc=0000 addr=0008",
               bus.out_valid, bus.out_pc, bus.imem_addr);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_pc} !== {1'b1, 16'(4 * (i + 1))}) begin
        n_fail++;
        $display("FAIL bp_release[%0d]: got v=%b pc=%h expected v=1 pc=%h",
                 i, bus.out_valid, bus.out_pc, 16'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_redirect_full();
    bus.out_ready = 1'b0;
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    n_checks++;
    if ({bus.out_valid, bus.imem_addr, busy} !== {1'b0, 16'h0040, 1'b1}) begin
      n_fail++;
      $display("FAIL redir_flush: got v=%b addr=%h busy=%b expected v=0 addr=0040 busy=1",
               bus.out_valid, bus.imem_addr, busy);
    end
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_pc} !== {1'b1, 16'h0040}) begin
      n_fail++;
      $display("FAIL redir_first: got v=%b pc=%h expected v=1 pc=0040", bus.out_valid, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_pc} !== {1'b1, 16'(16'h40 + 4 * (i + 1))} || obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL redir_seq[%0d]: got v=%b pc=%h expected v=1 pc=%h",
                 i, bus.out_valid, bus.out_pc, 16'(16'h40 + 4 * (i + 1)));
      end
    end
  endtask

  task automatic test_fault_end();
    bit seen_last = 0;
    int guard = 0;
    bus.out_ready = 1'b1;
    redirect      = 1'b1;
    redirect_pc   = 16'd1000;
    tick();
    redirect = 1'b0;
    while (!fault && guard < 40) begin
      tick();
      guard++;
      if (bus.out_valid && bus.out_pc == 16'd1020) seen_last = 1;
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL end_walk[%0d]: got %h expected %h", guard, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (!seen_last || guard >= 40) begin
      n_fail++;
      $display("FAIL end_reach: got seen1020=%b cycles=%0d expected seen1020=1 within 40", seen_last, guard);
    end
    n_checks++;
    if ({fault, fault_pc, bus.out_valid, busy} !== {1'b1, 16'h0400, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL end_fault: got f=%b fpc=%h v=%b busy=%b expected f=1 fpc=0400 v=0 busy=0",
               fault, fault_pc, bus.out_valid, busy);
    end
  endtask

  task automatic test_misaligned();
    redirect    = 1'b1;
    redirect_pc = 16'h0006;
    tick();
    redirect = 1'b0;
    n_checks++;
    if ({fault, busy, bus.imem_addr} !== {1'b0, 1'b1, 16'h0006}) begin
      n_fail++;
      $display("FAIL mis_clear: got f=%b busy=%b addr=%h expected f=0 busy=1 addr=0006",
               fault, busy, bus.imem_addr);
    end
    tick();
    n_checks++;
    if ({fault, fault_pc, bus.out_valid} !== {1'b1, 16'h0006, 1'b0}) begin
      n_fail++;
      $display("FAIL mis_fault: got f=%b fpc=%h v=%b expected f=1 fpc=0006 v=0", fault, fault_pc, bus.out_valid);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++;
    if ({fault, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL mis_start_ignored: got f=%b busy=%b expected f=1 busy=0", fault, busy);
    end
    redirect    = 1'b1;
    redirect_pc = 16'h0000;
    tick();
    redirect = 1'b0;
    n_checks++;
    if ({fault, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL mis_resume: got f=%b busy=%b expected f=0 busy=1", fault, busy);
    end
    tick();
    n_checks++;
    if ({bus.out_valid, bus.out_pc} !== {1'b1, 16'h0}) begin
      n_fail++;
      $display("FAIL mis_refetch: got v=%b pc=%h expected v=1 pc=0000", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.out_valid, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL areset_pre: got v=%b busy=%b expected 1 1", bus.out_valid, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, busy, bus.imem_addr, bus.out_pc} !== {1'b0, 1'b0, RESET_PC, 16'h0}) begin
      n_fail++;
      $display("FAIL areset_now: got v=%b busy=%b addr=%h pc=%h expected v=0 busy=0 addr=%h pc=0000",
               bus.out_valid, busy, bus.imem_addr, bus.out_pc, RESET_PC);
    end
    #2 reset = 1'b0;
    tick();
    n_checks++;
    if (obs_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL areset_after: got %h expected %h", obs_vec, exp_vec);
    end
    bus.out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    halt        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0080;
    tick();
    halt     = 1'b0;
    redirect = 1'b0;
    n_checks++;
    if ({busy, bus.out_valid, fault} !== 3'b000 || bus.imem_addr === 16'h0080 || obs_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL halt_beats_redirect: got busy=%b v=%b f=%b addr=%h expected halted, addr!=0080",
               busy, bus.out_valid, fault, bus.imem_addr);
    end
  endtask

  task automatic test_random();
    start = 1'b0; halt = 1'b0; redirect = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      start         = ($urandom_range(0, 15) == 0);
      halt          = ($urandom_range(0, 63) == 0);
      redirect      = ($urandom_range(0, 19) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: redirect_pc = 16'($urandom_range(0, 255) * 4);
        6, 7:             redirect_pc = 16'(MEM_SIZE - 4 * $urandom_range(1, 6));
        8:                redirect_pc = 16'($urandom);
        default:          redirect_pc = 16'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
      endcase
      tick();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h expected %h", c, obs_vec, exp_vec);
      end
    end
    start = 1'b0; halt = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_fault_end();
    test_misaligned();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter MEM_SIZE, default 1024, instruction memory size in bytes (power of two).
REQ-002 Parameter DEPTH, default 2, prefetch queue entries (power of two, >=2).
REQ-003 Parameter RESET_PC, default 16'h0000, first fetch address after start.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  reset, asynchronous and active-high.
REQ-006 start  in  1  begin fetching at RESET_PC; honoured in IDLE and HALTED only.
REQ-007 halt  in  1  stop fetching, flush queue.
REQ-008 redirect  in  1  branch or jump; flush queue, refetch from redirect_pc.
REQ-009 redirect_pc  in  16  byte address of the new fetch target.
REQ-010 imem_addr  out  16  byte address driven to the combinational instruction ROM.
REQ-011 imem_instr  in  16  ROM read data, valid in the same cycle as imem_addr.
REQ-012 out_valid  out  1  queue head holds a valid instruction.
REQ-013 out_instr  out  16  queue head instruction.
REQ-014 out_pc  out  16  queue head byte address.
REQ-015 out_ready  in  1  consumer accepts the head this cycle.
REQ-016 fault  out  1  fetch stopped on a bad address.
REQ-017 fault_pc  out  16  offending address, held while fault=1.
REQ-018 busy  out  1  state is FETCH.

Function
REQ-019 FSM SHALL have states IDLE, FETCH, HALTED, FAULT.
REQ-020 IDLE/HALTED + start -> FETCH, fetch_pc<=RESET_PC, queue empty.
REQ-021 imem_addr SHALL equal fetch_pc in every state.
REQ-022 FETCH push: when fetch_pc is legal and (queue not full or pop this cycle), push {fetch_pc, imem_instr}, then fetch_pc+=4, wrapping modulo 2^16.
REQ-023 Legal address: fetch_pc[1:0]==0 and fetch_pc+3 < MEM_SIZE, with the sum computed 17 bits wide.
REQ-024 Pop when out_valid & out_ready; push and pop in the same cycle SHALL be allowed when full; count unchanged.
REQ-025 Illegal fetch_pc in FETCH: no push; when the queue is empty -> FAULT, fault_pc<=fetch_pc; queued entries drain normally first.
REQ-026 redirect (FETCH or FAULT): flush queue, discard the same-cycle push, do not pop, fetch_pc<=redirect_pc, state->FETCH, fault clears next cycle.
REQ-027 halt in FETCH or FAULT -> HALTED, queue flushed; halt beats redirect, which beats push/pop.
REQ-028 Latency: first out_valid SHALL appear 2 cycles after start is sampled (1 cycle to load fetch_pc, 1 cycle to push).
REQ-029 Steady state with out_ready=1: one instruction per cycle, with consecutive out_pc differing by 4.
REQ-030 out_valid=0 in IDLE and HALTED; out_instr/out_pc hold the last head value when out_valid=0.
REQ-031 start in FETCH or FAULT SHALL be ignored.

Reset
REQ-032 Reset SHALL force state IDLE, fetch_pc=RESET_PC, queue empty, out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0, busy=0, imem_addr=RESET_PC.
REQ-033 Reset asserted mid-operation SHALL drop all queued entries at once, with no pop handshake.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum and the queue-entry struct {pc[15:0], instr[15:0]}.
REQ-035 The queue SHALL be sub-module fetch_queue (DEPTH-entry circular FIFO with flush, push, pop, full, empty).
REQ-036 No combinational path from out_ready to imem_addr.

Verification
REQ-037 start, out_ready=1, MEM_SIZE=1024 -> out_pc 0,4,8,... one per cycle; first valid 2 cycles after start.
REQ-038 out_ready=0 for 5 cycles after start -> queue holds pc 0,4; fetch_pc stays 8; pc 4 is never duplicated on release.
REQ-039 redirect_pc=16'h0040 while full -> next valid out_pc=0x40; entries 0/4 never seen after the redirect.
REQ-040 Sequential fetch reaches 1020 then 1024 -> 1020 delivered; then fault=1, fault_pc=0x0400, out_valid=0.
REQ-041 redirect_pc=16'h0006 -> FAULT with fault_pc=0x0006; then redirect_pc=0 -> fault clears, fetch resumes at 0.
REQ-042 reset asserted between clock edges while full -> out_valid and busy go 0 immediately; halt+redirect in the same cycle -> HALTED.
